pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Control-side counterpart of the program counter. It reads the instruction fetched from program memory at CounterValue and drives the PC's LoadValue, LoadEnable, Offset and OffsetEnable inputs.
- Implements a two-cycle fetch/decode FSM with conditional relative branches, absolute jumps, CALL/RET with a hardware return-address stack, and HALT.
- Sits between the PC, the synchronous program ROM and the ALU flag register.

Parameters:
StackDepth, 8, number of 16-bit return-address entries (power of 2, 2..64)
PtrWidth, $clog2(StackDepth)+1, stack pointer width (derived; 0..StackDepth)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high
Instruction  input  16  ROM data, valid one cycle after CounterValue changes
CounterValue  input  16  current PC value
Zero  input  1  ALU zero flag
Negative  input  1  ALU negative flag
Carry  input  1  ALU carry flag
LoadValue  output  16  absolute target to PC
LoadEnable  output  1  PC loads LoadValue at next edge
Offset  output  9  signed offset to PC
OffsetEnable  output  1  PC adds Offset at next edge (Offset=0 means hold)
Halted  output  1  high while in HALTED
StackError  output  1  sticky; set on overflow or underflow
StackPointer  output  PtrWidth  number of valid stack entries

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named Clock and Reset.
- PC contract: with both enables low, the PC increments by 1. The sequencer never asserts LoadEnable and OffsetEnable in the same cycle.
- Reset (sync, any state, including mid-instruction): state=FETCH, StackPointer=0, StackError=0, Halted=0, LoadValue=0, LoadEnable=0, Offset=0, OffsetEnable=0.
- FSM states: FETCH, DECODE, HALTED. Outputs are combinational from state, Instruction, flags and stack top.
- FETCH: OffsetEnable=1, Offset=0 (PC held while ROM latency elapses); next state DECODE.
- DECODE: acts on Instruction; next state FETCH unless noted. Every instruction therefore takes 2 cycles, and CounterValue during DECODE is the address of the instruction being decoded.
- Opcode is Instruction[15:12]. Opcodes 0x0-0x7 and 0xD-0xF are non-control: all enables low, so the PC increments.
- 0x8 BR: cond=[11:9], off=[8:0] signed.
  - cond codes: 000 always; 001 Z; 010 !Z; 011 N; 100 !N; 101 C; 110 !C; 111 never.
  - Flags are sampled in the DECODE cycle.
  - Taken: OffsetEnable=1, Offset=off, so next PC = CounterValue + sign-extended off (mod 2^16; wrap allowed).
  - Not taken: enables low (increment).
- 0x9 JMP: LoadEnable=1, LoadValue={4'h0, Instruction[11:0]}.
- 0xA CALL:
  - If StackPointer < StackDepth: push CounterValue+1 (mod 2^16) at the next edge, StackPointer+1, LoadEnable=1, LoadValue={4'h0,[11:0]}.
  - If full: no push, StackError<=1, OffsetEnable=1, Offset=0, next state HALTED.
- 0xB RET:
  - If StackPointer > 0: LoadEnable=1, LoadValue=top entry, StackPointer-1 at the next edge.
  - If empty: StackError<=1, hold, next state HALTED.
- 0xC HALT: hold (OffsetEnable=1, Offset=0), next state HALTED.
- HALTED: OffsetEnable=1, Offset=0, Halted=1; exits only on Reset. StackError stays set until Reset.
- Stack: LIFO. Push and pop never occur in the same cycle. Entries are not cleared on reset; only the pointer is.
- When enables are low, LoadValue and Offset are don't-care but must be driven to 0.

Test Plan:
- Reset then ROM all 0x0000 -> CounterValue 0,0,1,1,2,2,... (each address held 2 cycles); enables low in every DECODE cycle.
- At PC=0x0010, Instruction=0x81FF (BR always, off=-1) -> in DECODE, OffsetEnable=1, Offset=-1, next PC=0x000F.
- Instruction=0x8205 (BR if Z) with Zero=0 -> no enables, PC 0x0010->0x0011; same instruction with Zero=1 -> PC=0x0015.
- At PC=0x0020, 0xA123 (CALL 0x123) -> PC=0x0123, StackPointer=1; then 0xB000 (RET) -> LoadValue=0x0021, PC=0x0021, StackPointer=0.
- Nine CALLs with StackDepth=8 -> ninth sets StackError=1 and Halted=1, PC frozen; RET with empty stack after reset -> same result; Reset then clears both.
- Assert Reset during the DECODE of a CALL -> next cycle StackPointer=0, state FETCH, no push; 0xC000 (HALT) -> Halted=1 and PC constant for 20 cycles.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer that steers the program counter: branches, jumps,
// CALL/RET through a hardware return-address stack, and HALT.
module pc_sequencer #(
    parameter int StackDepth = 8,
    parameter int PtrWidth   = $clog2(StackDepth) + 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [15:0]         Instruction,
    input  logic [15:0]         CounterValue,
    input  logic                Zero,
    input  logic                Negative,
    input  logic                Carry,
    output logic [15:0]         LoadValue,
    output logic                LoadEnable,
    output logic [8:0]          Offset,
    output logic                OffsetEnable,
    output logic                Halted,
    output logic                StackError,
    output logic [PtrWidth-1:0] StackPointer
);

    localparam int IdxWidth = PtrWidth - 1;
    localparam logic [PtrWidth-1:0] FullCount = PtrWidth'(StackDepth);

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        HALTED
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [15:0]   stack_mem [StackDepth];
    logic [15:0]   top_entry;
    logic [PtrWidth-1:0] top_ptr;
    logic [3:0]    opcode;
    logic          taken;
    logic          push;
    logic          pop;
    logic          set_error;
    logic          stack_full;
    logic          stack_empty;

    assign opcode      = Instruction[15:12];
    assign stack_full  = (StackPointer >= FullCount);
    assign stack_empty = (StackPointer == '0);
    assign top_ptr     = StackPointer - PtrWidth'(1);
    assign top_entry   = stack_mem[top_ptr[IdxWidth-1:0]];

    always_comb begin
        taken = 1'b0;
        case (Instruction[11:9])
            3'b000:  taken = 1'b1;
            3'b001:  taken = Zero;
            3'b010:  taken = !Zero;
            3'b011:  taken = Negative;
            3'b100:  taken = !Negative;
            3'b101:  taken = Carry;
            3'b110:  taken = !Carry;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= FETCH;
            StackPointer <= '0;
            StackError   <= 1'b0;
        end else begin
            state <= next_state;
            if (push) begin
                StackPointer <= StackPointer + PtrWidth'(1);
            end else if (pop) begin
                StackPointer <= StackPointer - PtrWidth'(1);
            end
            if (set_error) begin
                StackError <= 1'b1;
            end
        end
    end

    // Stack entries survive reset; only the pointer is cleared.
    always_ff @(posedge Clock) begin
        if (push) begin
            stack_mem[StackPointer[IdxWidth-1:0]] <= CounterValue + 16'd1;
        end
    end

    // While Reset is asserted all controls are idle so the PC sees a quiet bus.
    always_comb begin
        next_state   = state;
        LoadValue    = 16'h0000;
        LoadEnable   = 1'b0;
        Offset       = 9'h000;
        OffsetEnable = 1'b0;
        Halted       = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        set_error    = 1'b0;
        if (Reset) begin
            next_state = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    OffsetEnable = 1'b1;
                    next_state   = DECODE;
                end
                DECODE: begin
                    next_state = FETCH;
                    case (opcode)
                        4'h8: begin
                            if (taken) begin
                                OffsetEnable = 1'b1;
                                Offset       = Instruction[8:0];
                            end
                        end
                        4'h9: begin
                            LoadEnable = 1'b1;
                            LoadValue  = {4'h0, Instruction[11:0]};
                        end
                        4'hA: begin
                            if (!stack_full) begin
                                push       = 1'b1;
                                LoadEnable = 1'b1;
                                LoadValue  = {4'h0, Instruction[11:0]};
                            end else begin
                                set_error    = 1'b1;
                                OffsetEnable = 1'b1;
                                next_state   = HALTED;
                            end
                        end
                        4'hB: begin
                            if (!stack_empty) begin
                                pop        = 1'b1;
                                LoadEnable = 1'b1;
                                LoadValue  = top_entry;
                            end else begin
                                set_error    = 1'b1;
                                OffsetEnable = 1'b1;
                                next_state   = HALTED;
                            end
                        end
                        4'hC: begin
                            OffsetEnable = 1'b1;
                            next_state   = HALTED;
                        end
                        default: begin
                        end
                    endcase
                end
                HALTED: begin
                    OffsetEnable = 1'b1;
                    Halted       = 1'b1;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

endmodule
